// File: rtl/bm3d_pkg.sv
// bm3d_pkg: constants shared by the BM3D window filter files.
//   - output mode encoding (bypass / window mean)
//   - fixed-point reciprocals of the window area (Q16) and the shift that undoes them
//   - end-to-end pipeline latency, which applies in both modes
package bm3d_pkg;

   localparam logic ModeBypass = 1'b0;
   localparam logic ModeMean   = 1'b1;

   // round(65536 / 9) and round(65536 / 25)
   localparam int unsigned Recip3     = 7282;
   localparam int unsigned Recip5     = 2621;
   localparam int unsigned RecipShift = 16;
   localparam int unsigned RoundBias  = 1 << (RecipShift - 1);

   localparam int unsigned PipeLat = 4;

   function automatic int unsigned recip_for(input int unsigned win);
      return (win == 5) ? Recip5 : Recip3;
   endfunction

endpackage

// File: rtl/bm3d_line_buf.sv
// bm3d_line_buf: one line of pixel storage.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write column
//   wdata_i : write pixel
//   raddr_i : read column
//   rdata_o : pixel at raddr_i, one cycle after the address is presented
// Contents are deliberately not reset.
module bm3d_line_buf #(
   parameter int unsigned Depth = 1280,
   parameter int unsigned Width = 8,
   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);

   logic [Width-1:0] mem [Depth];
   logic [Width-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bm3d_win_filt.sv
// bm3d_win_filt: streaming WIN x WIN box-mean filter for a DVP-style camera stream.
//   clk, rst            : clock, asynchronous active-high reset
//   vsync/href/cmos_de  : frame sync, line valid, pixel valid
//   data_in             : input pixel
//   mode                : 0 bypass, 1 window mean; latched on the vsync rising edge
//   o_vsync/o_href/o_de : sync inputs delayed 4 cycles
//   data_out            : output pixel, 4 cycles after its input, 0 whenever o_de is low
//   frame_cnt           : frames seen, only when BM3D_FRAME_CNT_EN is defined
// Pipeline: line-buffer read / window shift, per-row sums, total sum, multiply-round-saturate.
module bm3d_win_filt
   import bm3d_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned LINE_MAX = 1280,
   parameter int unsigned WIN      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              href,
   input  logic              cmos_de,
   input  logic [DATA_W-1:0] data_in,
   input  logic              mode,
   output logic              o_vsync,
   output logic              o_href,
   output logic              o_de,
   output logic [DATA_W-1:0] data_out
`ifdef BM3D_FRAME_CNT_EN
   ,
   output logic [15:0]       frame_cnt
`endif
);

   localparam int unsigned NBuf   = WIN - 1;
   localparam int unsigned ColW   = $clog2(LINE_MAX + 1);
   localparam int unsigned AddrW  = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
   localparam int unsigned RowW   = 16;
   localparam int unsigned RSumW  = DATA_W + 3;
   localparam int unsigned SumW   = DATA_W + 5;
   localparam int unsigned Recip  = recip_for(WIN);
   localparam int unsigned MaxPix = (1 << DATA_W) - 1;

   localparam logic [ColW-1:0] LineMaxC = ColW'(LINE_MAX);
   localparam logic [ColW-1:0] EdgeCol  = ColW'(WIN - 1);
   localparam logic [RowW-1:0] EdgeRow  = RowW'(WIN - 1);

   // sync delay lines; bit 0 doubles as the previous-cycle value for edge detection
   logic [PipeLat-1:0] vs_q, hr_q, de_q;
   // per-pixel output selection travelling alongside the datapath
   logic [PipeLat-2:0] bp_q, mn_q;
   logic [DATA_W-1:0]  dly_q [PipeLat-1];
   logic [DATA_W-1:0]  data_out_q, data_out_d;

   logic [ColW-1:0] col_q, col_d;
   logic [RowW-1:0] row_q, row_d;
   logic            mode_q, armed_q;
   logic            vs_rise, hr_fall, in_line, in_win, bp_in, mn_in;

   logic [DATA_W-1:0] lb_rd   [NBuf];
   logic [DATA_W-1:0] col_vec [WIN];
   logic [DATA_W-1:0] win_q   [WIN][WIN];
   logic [RSumW-1:0]  rsum_d  [WIN];
   logic [RSumW-1:0]  rsum_q  [WIN];
   logic [SumW-1:0]   total_d, total_q;
   logic [31:0]       prod, mean_full;
   logic [DATA_W-1:0] mean_sat;
   logic [AddrW-1:0]  rd_addr;

   assign vs_rise = vsync & ~vs_q[0];
   assign hr_fall = ~href & hr_q[0];
   assign in_line = col_q < LineMaxC;
   assign in_win  = (row_q >= EdgeRow) & (col_q >= EdgeCol) & in_line;
   assign bp_in   = armed_q & cmos_de & (mode_q == ModeBypass);
   assign mn_in   = armed_q & cmos_de & (mode_q == ModeMean) & in_win;

   always_comb begin
      col_d = col_q;
      if (hr_fall) begin
         col_d = '0;
      end else if (cmos_de && in_line) begin
         col_d = col_q + ColW'(1);
      end
   end

   always_comb begin
      row_d = row_q;
      if (vs_rise) begin
         row_d = '0;
      end else if (hr_fall && (row_q != '1)) begin
         row_d = row_q + RowW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         mode_q  <= ModeBypass;
         armed_q <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         if (vs_rise) begin
            mode_q  <= mode;
            armed_q <= 1'b1;
         end
      end
   end

   // Reading at the next column address makes the stored column for the pixel that is about
   // to arrive available in the same cycle, so the RAM latency costs no extra stage.
   assign rd_addr = (col_d < LineMaxC) ? col_d[AddrW-1:0] : '0;

   // Buffers form a chain: each write pushes the older line's pixel one buffer further back.
   for (genvar i = 0; i < NBuf; i++) begin : g_lb
      logic [DATA_W-1:0] wdata;
      if (i == 0) begin : g_head
         assign wdata = data_in;
      end else begin : g_tail
         assign wdata = lb_rd[i-1];
      end
      bm3d_line_buf #(
         .Depth(LINE_MAX),
         .Width(DATA_W)
      ) u_line_buf (
         .clk_i  (clk),
         .we_i   (cmos_de & in_line),
         .waddr_i(col_q[AddrW-1:0]),
         .wdata_i(wdata),
         .raddr_i(rd_addr),
         .rdata_o(lb_rd[i])
      );
   end

   // col_vec[0] is the current row, col_vec[r] the row r lines above
   always_comb begin
      col_vec[0] = data_in;
      for (int r = 1; r < WIN; r++) begin
         col_vec[r] = lb_rd[r-1];
      end
   end

   always_comb begin
      for (int r = 0; r < WIN; r++) begin
         rsum_d[r] = '0;
         for (int c = 0; c < WIN; c++) begin
            rsum_d[r] = rsum_d[r] + RSumW'(win_q[r][c]);
         end
      end
   end

   always_comb begin
      total_d = '0;
      for (int r = 0; r < WIN; r++) begin
         total_d = total_d + SumW'(rsum_q[r]);
      end
   end

   assign prod      = 32'(total_q) * Recip + RoundBias;
   assign mean_full = prod >> RecipShift;
   assign mean_sat  = (mean_full > MaxPix) ? '1 : mean_full[DATA_W-1:0];

   always_comb begin
      data_out_d = '0;
      if (bp_q[PipeLat-2]) begin
         data_out_d = dly_q[PipeLat-2];
      end else if (mn_q[PipeLat-2]) begin
         data_out_d = mean_sat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < WIN; r++) begin
            rsum_q[r] <= '0;
            for (int c = 0; c < WIN; c++) begin
               win_q[r][c] <= '0;
            end
         end
         total_q <= '0;
      end else begin
         // window columns only advance on a valid pixel; column 0 is the newest
         if (cmos_de) begin
            for (int r = 0; r < WIN; r++) begin
               win_q[r][0] <= col_vec[r];
               for (int c = 1; c < WIN; c++) begin
                  win_q[r][c] <= win_q[r][c-1];
               end
            end
         end
         for (int r = 0; r < WIN; r++) begin
            rsum_q[r] <= rsum_d[r];
         end
         total_q <= total_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_q       <= '0;
         hr_q       <= '0;
         de_q       <= '0;
         bp_q       <= '0;
         mn_q       <= '0;
         data_out_q <= '0;
         for (int i = 0; i < PipeLat - 1; i++) begin
            dly_q[i] <= '0;
         end
      end else begin
         vs_q       <= {vs_q[PipeLat-2:0], vsync};
         hr_q       <= {hr_q[PipeLat-2:0], href};
         de_q       <= {de_q[PipeLat-2:0], cmos_de};
         bp_q       <= {bp_q[PipeLat-3:0], bp_in};
         mn_q       <= {mn_q[PipeLat-3:0], mn_in};
         data_out_q <= data_out_d;
         dly_q[0]   <= data_in;
         for (int i = 1; i < PipeLat - 1; i++) begin
            dly_q[i] <= dly_q[i-1];
         end
      end
   end

   assign o_vsync  = vs_q[PipeLat-1];
   assign o_href   = hr_q[PipeLat-1];
   assign o_de     = de_q[PipeLat-1];
   assign data_out = data_out_q;

`ifdef BM3D_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else if (vs_rise) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_bm3d_win_filt.sv
// tb_bm3d_win_filt: drives a WIN=3 and a WIN=5 filter from one randomized camera stream and
// checks both against an image-array reference model of the filter behaviour.
module tb_bm3d_win_filt;

   localparam int DW = 8;
   localparam int LM = 16;
   localparam int MaxRows = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vsync = 1'b0, href = 1'b0, cmos_de = 1'b0, mode = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          o_vsync3, o_href3, o_de3, o_vsync5, o_href5, o_de5;
   logic [DW-1:0] dout3, dout5;
`ifdef BM3D_FRAME_CNT_EN
   logic [15:0]   frame_cnt3, frame_cnt5;
`endif

   always #5 clk = ~clk;

   bm3d_win_filt #(.DATA_W(DW), .LINE_MAX(LM), .WIN(3)) u_dut3 (
      .clk(clk), .rst(rst), .vsync(vsync), .href(href), .cmos_de(cmos_de),
      .data_in(data_in), .mode(mode), .o_vsync(o_vsync3), .o_href(o_href3),
      .o_de(o_de3), .data_out(dout3)
`ifdef BM3D_FRAME_CNT_EN
      , .frame_cnt(frame_cnt3)
`endif
   );

   bm3d_win_filt #(.DATA_W(DW), .LINE_MAX(LM), .WIN(5)) u_dut5 (
      .clk(clk), .rst(rst), .vsync(vsync), .href(href), .cmos_de(cmos_de),
      .data_in(data_in), .mode(mode), .o_vsync(o_vsync5), .o_href(o_href5),
      .o_de(o_de5), .data_out(dout5)
`ifdef BM3D_FRAME_CNT_EN
      , .frame_cnt(frame_cnt5)
`endif
   );

   typedef struct {
      bit vs;
      bit hr;
      bit de;
      int d3;
      int d5;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // reference model state
   int   m_row, m_col, m_frames;
   bit   m_vs_prev, m_hr_prev, m_armed, m_mode;
   int   img [MaxRows][LM];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int win_mean(input int win, input int y, input int x);
      int s, r, v;
      s = 0;
      for (int dy = 0; dy < win; dy++) begin
         for (int dx = 0; dx < win; dx++) begin
            s += img[y-dy][x-dx];
         end
      end
      r = (win == 3) ? 7282 : 2621;
      v = (s * r + 32768) >>> 16;
      return (v > 255) ? 255 : v;
   endfunction

   task automatic model_reset();
      m_row = 0; m_col = 0; m_frames = 0;
      m_vs_prev = 0; m_hr_prev = 0; m_armed = 0; m_mode = 0;
   endtask

   task automatic check_outputs(input exp_t e);
      chk("dut3.o_vsync", o_vsync3, e.vs);
      chk("dut3.o_href", o_href3, e.hr);
      chk("dut3.o_de", o_de3, e.de);
      chk("dut3.data_out", dout3, e.d3);
      chk("dut5.o_vsync", o_vsync5, e.vs);
      chk("dut5.o_href", o_href5, e.hr);
      chk("dut5.o_de", o_de5, e.de);
      chk("dut5.data_out", dout5, e.d5);
   endtask

   // one clock: check the output due now, then apply the next input and predict its output
   task automatic tick(input bit v, input bit h, input bit de, input int d, input bit m);
      exp_t e;
      bit   rise, fall;
      @(negedge clk);
      if (q.size() >= 4) begin
         e = q.pop_front();
         check_outputs(e);
      end
`ifdef BM3D_FRAME_CNT_EN
      chk("dut3.frame_cnt", frame_cnt3, m_frames & 16'hFFFF);
      chk("dut5.frame_cnt", frame_cnt5, m_frames & 16'hFFFF);
`endif
      vsync = v; href = h; cmos_de = de; data_in = d[DW-1:0]; mode = m;
      rise = v && !m_vs_prev;
      fall = !h && m_hr_prev;
      e.vs = v; e.hr = h; e.de = de; e.d3 = 0; e.d5 = 0;
      if (de && m_col < LM && m_row < MaxRows) img[m_row][m_col] = d & 255;
      if (de && m_armed) begin
         if (!m_mode) begin
            e.d3 = d & 255;
            e.d5 = d & 255;
         end else if (m_col < LM && m_row < MaxRows) begin
            if (m_row >= 2 && m_col >= 2) e.d3 = win_mean(3, m_row, m_col);
            if (m_row >= 4 && m_col >= 4) e.d5 = win_mean(5, m_row, m_col);
         end
      end
      q.push_back(e);
      if (fall) m_col = 0;
      else if (de && m_col < LM) m_col++;
      if (rise) m_row = 0;
      else if (fall) m_row++;
      if (rise) begin
         m_mode = m;
         m_armed = 1;
         m_frames++;
      end
      m_vs_prev = v;
      m_hr_prev = h;
   endtask

   task automatic do_reset();
      exp_t z;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      z.vs = 0; z.hr = 0; z.de = 0; z.d3 = 0; z.d5 = 0;
      check_outputs(z);
      q.delete();
      vsync = 0; href = 0; cmos_de = 0; data_in = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      // outputs for the next four cycles come from cleared registers or idle inputs
      repeat (4) q.push_back(z);
   endtask

   function automatic int pix(input int pat, input int cval, input int x, input int y,
                              input int w);
      if (pat == 0) return (y * w + x) & 255;
      if (pat == 1) return cval;
      return $urandom_range(0, 255);
   endfunction

   // pat: 0 ramp, 1 constant cval, 2 random; long_row gets LM+4 pixels; abort_row resets
   // mid-line and abandons the rest of the frame
   task automatic frame(input int w, input int h, input bit md, input int pat, input int cval,
                        input int long_row, input bit gaps, input bit toggle,
                        input int abort_row);
      bit tm;
      int lw, x;
      tick(1, 0, 0, $urandom_range(0, 255), md);
      tm = toggle ? !md : md;
      repeat (2) tick(1, 0, 0, $urandom_range(0, 255), tm);
      repeat (2) tick(0, 0, 0, $urandom_range(0, 255), tm);
      for (int y = 0; y < h; y++) begin
         lw = (y == long_row) ? LM + 4 : w;
         x = 0;
         while (x < lw) begin
            if (y == abort_row && x == w / 2) begin
               do_reset();
               return;
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
               tick(0, 1, 0, $urandom_range(0, 255), tm);
            end else begin
               tick(0, 1, 1, pix(pat, cval, x, y, w), tm);
               x++;
            end
         end
         if (toggle) tm = !tm;
         repeat (3) tick(0, 0, 0, $urandom_range(0, 255), tm);
      end
   endtask

   initial begin
      model_reset();
      do_reset();
      // before the first vsync: syncs propagate, pixels stay 0
      for (int y = 0; y < 2; y++) begin
         for (int x = 0; x < 8; x++) tick(0, 1, 1, $urandom_range(0, 255), 1'b1);
         repeat (3) tick(0, 0, 0, 0, 1'b1);
      end
      frame(8, 6, 1'b0, 0, 0, -1, 1'b0, 1'b0, -1);     // bypass ramp
      frame(16, 6, 1'b1, 1, 100, -1, 1'b0, 1'b0, -1);  // mean, constant 100
      frame(16, 6, 1'b1, 1, 255, -1, 1'b0, 1'b0, -1);  // mean, constant 255
      frame(16, 7, 1'b1, 2, 0, 3, 1'b1, 1'b1, -1);     // mean, random, long line, mode toggling
      frame(12, 5, 1'b0, 2, 0, -1, 1'b1, 1'b1, -1);    // bypass with mode toggling
      frame(16, 6, 1'b1, 2, 0, -1, 1'b0, 1'b0, 3);     // reset mid-frame
      repeat (6) tick(0, 1, 1, $urandom_range(0, 255), 1'b1);
      repeat (3) tick(0, 0, 0, 0, 1'b1);
      frame(16, 6, 1'b1, 2, 0, 2, 1'b1, 1'b0, -1);     // next frame after reset
      repeat (8) tick(0, 0, 0, 0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
